// File: rtl/mem_ctrl_if.sv
// Bus bundle between the IF/MEM requesters, the byte-wide RAM and mem_ctrl.
// Handshake: a requester raises *_req with stable address/data and holds it until
// the matching *_done pulse; a request still high in the cycle after done is a new one.
interface mem_ctrl_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  if_req;
   logic [31:0]           if_addr;
   logic [31:0]           if_rdata;
   logic                  if_done;

   logic                  mem_req;
   logic                  mem_we;
   logic [1:0]            mem_len;
   logic [31:0]           mem_addr;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;
   logic                  mem_done;

   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_we;
   logic [7:0]            ram_dout;
   logic [7:0]            ram_din;

   logic [5:0]            stall;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
      output if_rdata, if_done, mem_rdata, mem_done, ram_addr, ram_we, ram_dout, stall
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
      input  if_rdata, if_done, mem_rdata, mem_done, ram_addr, ram_we, ram_dout, stall
   );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port memory arbiter for IF and MEM: serialises word/half/byte accesses
// onto a byte-wide synchronous RAM and produces the pipeline stall vector.
module mem_ctrl #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   mem_ctrl_if.slave   bus,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [2:0]            r_cnt;
   logic [2:0]            r_n;
   logic                  r_own_mem;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [31:0]           r_wdata;
   logic [31:0]           r_rbuf;
   logic [31:0]           r_if_rdata;
   logic [31:0]           r_mem_rdata;

   logic [2:0]            w_mem_n;
   logic [1:0]            w_cap_lane;
   logic [31:0]           w_rbuf_next;
   logic                  w_last_cap;
   logic                  w_issue;
   logic                  w_stall_mem;
   logic                  w_stall_if;

   assign w_mem_n    = (bus.mem_len == 2'd0) ? 3'd1 : (bus.mem_len == 2'd1) ? 3'd2 : 3'd4;
   assign w_cap_lane = 2'(r_cnt - 3'd1);
   assign w_last_cap = (r_state == S_READ) && (r_cnt == r_n);
   assign w_issue    = ((r_state == S_READ) && (r_cnt < r_n)) || (r_state == S_WRITE);

   // RAM data lags the address by one cycle, so count value c captures lane c-1.
   always_comb begin
      w_rbuf_next = r_rbuf;
      if (r_cnt != 3'd0) begin
         w_rbuf_next[{w_cap_lane, 3'b000} +: 8] = bus.ram_din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.mem_req) begin
               w_next = bus.mem_we ? S_WRITE : S_READ;
            end else if (bus.if_req) begin
               w_next = S_READ;
            end
         end
         S_READ:  if (r_cnt == r_n) w_next = S_DONE;
         S_WRITE: if (r_cnt == r_n - 3'd1) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.ram_addr = '0;
      bus.ram_we   = 1'b0;
      bus.ram_dout = 8'h00;
      if (w_issue) begin
         bus.ram_addr = r_base + ADDR_WIDTH'(r_cnt);
         bus.ram_we   = (r_state == S_WRITE);
         if (r_state == S_WRITE) begin
            bus.ram_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt       <= 3'd0;
         r_n         <= 3'd0;
         r_own_mem   <= 1'b0;
         r_base      <= '0;
         r_wdata     <= 32'h0;
         r_rbuf      <= 32'h0;
         r_if_rdata  <= 32'h0;
         r_mem_rdata <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt  <= 3'd0;
               r_rbuf <= 32'h0;
               if (bus.mem_req) begin
                  r_own_mem <= 1'b1;
                  r_base    <= ADDR_WIDTH'(bus.mem_addr);
                  r_n       <= w_mem_n;
                  r_wdata   <= bus.mem_wdata;
               end else if (bus.if_req) begin
                  r_own_mem <= 1'b0;
                  r_base    <= ADDR_WIDTH'(bus.if_addr);
                  r_n       <= 3'd4;
               end
            end
            S_READ: begin
               r_cnt  <= r_cnt + 3'd1;
               r_rbuf <= w_rbuf_next;
               // Commit on the final capture so rdata is already valid during the done pulse.
               if (w_last_cap) begin
                  if (r_own_mem) r_mem_rdata <= w_rbuf_next;
                  else           r_if_rdata  <= w_rbuf_next;
               end
            end
            S_WRITE: r_cnt <= r_cnt + 3'd1;
            default: r_cnt <= 3'd0;
         endcase
      end
   end

   assign bus.if_done   = (r_state == S_DONE) && !r_own_mem;
   assign bus.mem_done  = (r_state == S_DONE) &&  r_own_mem;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.mem_rdata = r_mem_rdata;

   assign w_stall_mem = bus.mem_req & ~bus.mem_done;
   assign w_stall_if  = bus.if_req  & ~bus.if_done;
   assign bus.stall   = w_stall_mem ? 6'b011111 : (w_stall_if ? 6'b000011 : 6'b000000);

   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, table vectors, arbitration and reset
// sequences, and random traffic scored against a transaction-level memory model.
module tb_mem_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;

   mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

   mem_ctrl #(.ADDR_WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_if  = 32'h0;
   logic [31:0] exp_mem = 32'h0;

   bit [7:0] pre_ram [bit [31:0]];
   bit [7:0] tb_ram  [bit [31:0]];
   bit [7:0] ref_mem [bit [31:0]];

   typedef struct {
      bit        is_mem;
      bit        we;
      bit [1:0]  len;
      bit [31:0] addr;
      bit [31:0] wdata;
      bit [31:0] exp_rdata;
      int        exp_lat;
   } vec_t;

   vec_t vecs[11];

   function automatic bit [7:0] init_byte(input bit [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   function automatic bit [7:0] ram_rd(input bit [31:0] a);
      if (tb_ram.exists(a)) return tb_ram[a];
      if (pre_ram.exists(a)) return pre_ram[a];
      return init_byte(a);
   endfunction

   function automatic bit [7:0] ref_rd(input bit [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_byte(a);
   endfunction

   function automatic int ref_n(input bit [1:0] len);
      return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit [31:0] ref_read(input bit [31:0] a, input int n);
      bit [31:0] r = 32'h0;
      for (int i = 0; i < n; i++) r[8*i +: 8] = ref_rd(a + 32'(i));
      return r;
   endfunction

   // Synchronous byte RAM: read data appears one cycle after the address.
   always @(posedge clk) begin
      if (bus.ram_we === 1'b1) tb_ram[bus.ram_addr] = bus.ram_dout;
      bus.ram_din <= ram_rd(bus.ram_addr);
   end

   task automatic preload(input bit [31:0] a, input bit [7:0] d);
      pre_ram[a] = d;
      ref_mem[a] = d;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic clear_req();
      bus.if_req    = 1'b0;
      bus.if_addr   = 32'h0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_len   = 2'd0;
      bus.mem_addr  = 32'h0;
      bus.mem_wdata = 32'h0;
   endtask

   task automatic txn(input string name, input bit is_mem, input bit we, input bit [1:0] len,
                      input bit [31:0] addr, input bit [31:0] wdata,
                      input bit [31:0] exp_rdata, input int exp_lat);
      int          n;
      int          lat = -1;
      int          ram_err = 0;
      int          stall_err = 0;
      int          hold_err = 0;
      int          pulse_err = 0;
      logic [5:0]  exp_stall;
      logic [31:0] got = 32'h0;
      logic [31:0] exp_val;
      n         = is_mem ? ref_n(len) : 4;
      exp_stall = is_mem ? 6'b011111 : 6'b000011;
      if (!we) exp_q.push_back(exp_rdata);
      @(negedge clk);
      if (is_mem) begin
         bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_len = len;
         bus.mem_addr = addr; bus.mem_wdata = wdata;
      end else begin
         bus.if_req = 1'b1; bus.if_addr = addr;
      end
      #1;
      if (bus.stall !== exp_stall) stall_err++;
      for (int k = 1; k <= 20 && lat < 0; k++) begin
         @(negedge clk);
         if (k <= n) begin
            if (bus.ram_we !== we || bus.ram_addr !== addr + 32'(k-1)) ram_err++;
            if (we && bus.ram_dout !== wdata[8*(k-1) +: 8]) ram_err++;
         end else if (bus.ram_we !== 1'b0 || bus.ram_addr !== 32'h0 || bus.ram_dout !== 8'h0) begin
            ram_err++;
         end
         if ((is_mem ? bus.if_done : bus.mem_done) !== 1'b0) pulse_err++;
         if ((is_mem ? bus.if_rdata : bus.mem_rdata) !== (is_mem ? exp_if : exp_mem)) hold_err++;
         if ((is_mem ? bus.mem_done : bus.if_done) === 1'b1) begin
            lat = k;
            got = is_mem ? bus.mem_rdata : bus.if_rdata;
            if (bus.stall !== 6'b0) stall_err++;
            clear_req();
         end else if (bus.stall !== exp_stall) begin
            stall_err++;
         end
      end
      if (lat < 0) clear_req();
      @(negedge clk);
      if (bus.if_done !== 1'b0 || bus.mem_done !== 1'b0) pulse_err++;
      chk({name, " latency"}, 32'(lat), 32'(exp_lat));
      chk({name, " ram_bus_errs"}, 32'(ram_err), 32'h0);
      chk({name, " stall_errs"}, 32'(stall_err), 32'h0);
      chk({name, " hold_errs"}, 32'(hold_err), 32'h0);
      chk({name, " pulse_errs"}, 32'(pulse_err), 32'h0);
      if (!we) begin
         exp_val = exp_q.pop_front();
         chk({name, " rdata"}, got, exp_val);
         if (is_mem) exp_mem = exp_val;
         else        exp_if  = exp_val;
      end else begin
         chk({name, " mem_rdata_held"}, bus.mem_rdata, exp_mem);
         for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int mem_k, if_k, if_start, errs, n, lat;
      logic [31:0] mem_val, if_val;
      bit is_mem, we;
      bit [1:0] len;
      bit [31:0] addr, wdata, exp;

      preload(32'h100, 8'h13); preload(32'h101, 8'h05);
      preload(32'h102, 8'h00); preload(32'h103, 8'h00);
      preload(32'h104, 8'hB7); preload(32'h105, 8'h12);
      preload(32'h106, 8'h34); preload(32'h107, 8'h00);
      preload(32'hFFFFFFFE, 8'hAA); preload(32'hFFFFFFFF, 8'h34);
      preload(32'h0, 8'h12); preload(32'h1, 8'h77);
      preload(32'h40, 8'h11); preload(32'h41, 8'h22);
      preload(32'h42, 8'h33); preload(32'h43, 8'h44);

      vecs[0]  = '{1'b0, 1'b0, 2'd2, 32'h100,      32'h0,        32'h00000513, 6};
      vecs[1]  = '{1'b1, 1'b1, 2'd2, 32'h20,       32'hDEADBEEF, 32'h0,        5};
      vecs[2]  = '{1'b1, 1'b0, 2'd0, 32'h21,       32'h0,        32'h000000BE, 3};
      vecs[3]  = '{1'b1, 1'b0, 2'd1, 32'hFFFFFFFF, 32'h0,        32'h00001234, 4};
      vecs[4]  = '{1'b1, 1'b0, 2'd2, 32'h20,       32'h0,        32'hDEADBEEF, 6};
      vecs[5]  = '{1'b1, 1'b1, 2'd1, 32'h41,       32'h1234ABCD, 32'h0,        3};
      vecs[6]  = '{1'b1, 1'b0, 2'd3, 32'h40,       32'h0,        32'h44ABCD11, 6};
      vecs[7]  = '{1'b1, 1'b1, 2'd0, 32'h43,       32'hFFFFFF5A, 32'h0,        2};
      vecs[8]  = '{1'b1, 1'b0, 2'd2, 32'h40,       32'h0,        32'h5AABCD11, 6};
      vecs[9]  = '{1'b0, 1'b0, 2'd2, 32'hFFFFFFFE, 32'h0,        32'h771234AA, 6};
      vecs[10] = '{1'b1, 1'b0, 2'd1, 32'h22,       32'h0,        32'h0000DEAD, 4};

      // Reset behaviour
      rst = 1'b0;
      clear_req();
      @(negedge clk);
      chk("reset state", 32'(dbg_state), 32'h0);
      chk("reset if_rdata", bus.if_rdata, 32'h0);
      chk("reset mem_rdata", bus.mem_rdata, 32'h0);
      chk("reset ram_addr", bus.ram_addr, 32'h0);
      chk("reset ram_we", 32'(bus.ram_we), 32'h0);
      chk("reset ram_dout", 32'(bus.ram_dout), 32'h0);
      chk("reset dones", {30'h0, bus.if_done, bus.mem_done}, 32'h0);
      chk("reset stall idle", 32'(bus.stall), 32'h0);
      bus.if_req = 1'b1; #1;
      chk("reset stall_if", 32'(bus.stall), 32'h03);
      bus.mem_req = 1'b1; #1;
      chk("reset stall_mem", 32'(bus.stall), 32'h1F);
      clear_req();
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 11; i++) begin
         txn($sformatf("vec%0d", i), vecs[i].is_mem, vecs[i].we, vecs[i].len,
             vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_lat);
      end

      // MEM and IF requested together: MEM first, IF starts after MEM's done
      @(negedge clk);
      bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'd2; bus.mem_addr = 32'h20;
      bus.if_req = 1'b1; bus.if_addr = 32'h104;
      #1;
      chk("arb stall start", 32'(bus.stall), 32'h1F);
      mem_k = -1; if_k = -1; if_start = -1; errs = 0;
      mem_val = 32'h0; if_val = 32'h0;
      for (int k = 1; k <= 30 && if_k < 0; k++) begin
         @(negedge clk);
         if (mem_k < 0) begin
            if (bus.if_done !== 1'b0) errs++;
            if (bus.mem_done === 1'b1) begin
               mem_k = k; mem_val = bus.mem_rdata;
               if (bus.stall !== 6'b000011) errs++;
               bus.mem_req = 1'b0;
            end else if (bus.stall !== 6'b011111) errs++;
         end else begin
            if (if_start < 0 && bus.ram_addr === 32'h104) if_start = k;
            if (bus.if_done === 1'b1) begin
               if_k = k; if_val = bus.if_rdata;
               if (bus.stall !== 6'b0) errs++;
               bus.if_req = 1'b0;
            end else if (bus.stall !== 6'b000011) errs++;
         end
         if (if_k < 0 && bus.if_rdata !== exp_if) errs++;
      end
      clear_req();
      @(negedge clk);
      chk("arb mem_done cycle", 32'(mem_k), 32'd6);
      chk("arb if first addr cycle", 32'(if_start), 32'd8);
      chk("arb if_done cycle", 32'(if_k), 32'd13);
      chk("arb mem_rdata", mem_val, 32'hDEADBEEF);
      chk("arb if_rdata", if_val, 32'h003412B7);
      chk("arb seq errs", 32'(errs), 32'h0);
      exp_mem = 32'hDEADBEEF;
      exp_if  = 32'h003412B7;

      // Reset asserted during the second byte of a word store
      @(negedge clk);
      bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd2;
      bus.mem_addr = 32'h80; bus.mem_wdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("rst-mid first write", {bus.ram_we, bus.ram_addr[30:0]}, {1'b1, 31'h80});
      @(negedge clk);
      rst = 1'b0; #1;
      chk("rst-mid ram_we", 32'(bus.ram_we), 32'h0);
      chk("rst-mid ram_addr", bus.ram_addr, 32'h0);
      chk("rst-mid state", 32'(dbg_state), 32'h0);
      chk("rst-mid stall", 32'(bus.stall), 32'h1F);
      chk("rst-mid rdata", bus.mem_rdata | bus.if_rdata, 32'h0);
      clear_req();
      errs = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.mem_done !== 1'b0 || bus.ram_we !== 1'b0) errs++;
      end
      rst = 1'b1;
      @(negedge clk);
      if (bus.mem_done !== 1'b0) errs++;
      chk("rst-mid no done", 32'(errs), 32'h0);
      exp_if = 32'h0; exp_mem = 32'h0;
      ref_mem[32'h80] = 8'h0D;
      txn("post-reset load", 1'b1, 1'b0, 2'd2, 32'h80, 32'h0, ref_read(32'h80, 4), 6);

      // Random traffic against the transaction-level model
      for (int i = 0; i < 40; i++) begin
         is_mem = 1'($urandom_range(0, 1));
         we     = is_mem & 1'($urandom_range(0, 1));
         len    = 2'($urandom_range(0, 3));
         addr   = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                              : 32'($urandom_range(0, 63));
         wdata  = $urandom;
         n      = is_mem ? ref_n(len) : 4;
         exp    = we ? 32'h0 : ref_read(addr, n);
         lat    = we ? n + 1 : n + 2;
         txn($sformatf("rand%0d", i), is_mem, we, len, addr, wdata, exp, lat);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      errs = 0;
      foreach (ref_mem[a]) if (ram_rd(a) !== ref_mem[a]) errs++;
      chk("final ram contents", 32'(errs), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
